// File: rtl/i2c_pkg.sv
// Shared I2C constants: bit-phase positions, byte-stage state encoding and the
// SDA drive polarity used for the acknowledge bit.
package i2c_pkg;

    // Bit period is 8 clocks, tracked by a 3-bit wrapping phase counter.
    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] PH_SCL_RISE = PHASE_W'(4);
    localparam logic [PHASE_W-1:0] PH_SAMPLE   = PHASE_W'(5);
    localparam logic [PHASE_W-1:0] PH_LAST     = PHASE_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    // Open-drain enable for the acknowledge slot: ACK pulls SDA low, NACK releases.
    localparam logic SDA_OE_ACK  = 1'b1;
    localparam logic SDA_OE_NACK = 1'b0;

endpackage

// File: rtl/i2c_bit_timer.sv
// I2C bit timer: 8-clock bit period phase counter and registered SCL.
// Ports:
//   clock, reset_n    system clock, async active-low reset
//   i_run             1 = advance phase (bit in progress), 0 = park at phase 0
//   i_scl_idle        SCL level to drive for the next cycle when not running
//   o_scl             registered SCL drive (low in phases 0-3, high in 4-7)
//   o_sample_c        phase is the SDA sample point
//   o_last_phase_c    phase is the final phase of the bit
module i2c_bit_timer
    import i2c_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_scl_idle,
    output logic o_scl,
    output logic o_sample_c,
    output logic o_last_phase_c
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               r_scl;

    // Counter wraps 7 -> 0 naturally; stopping parks it at phase 0.
    always_comb begin
        w_phase_next = '0;
        if (i_run) begin
            w_phase_next = r_phase + PHASE_W'(1);
        end
    end

    // SCL is registered from the next phase so it lines up with r_phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_scl   <= 1'b1;
        end else begin
            r_phase <= w_phase_next;
            r_scl   <= i_run ? (w_phase_next >= PH_SCL_RISE) : i_scl_idle;
        end
    end

    assign o_scl          = r_scl;
    assign o_sample_c     = (r_phase == PH_SAMPLE);
    assign o_last_phase_c = (r_phase == PH_LAST);

endmodule

// File: rtl/i2c_master_read_byte.sv
// I2C master byte receive stage: clocks in DATA_WIDTH bits MSB-first, then
// drives ACK/NACK and pulses o_finish with the assembled byte on o_data_out.
// Ports:
//   clock, reset_n  system clock, async active-low reset
//   i_go            transfer request, held for the whole transfer
//   i_ack_en        1 = ACK after byte, 0 = NACK; captured when go is accepted
//   o_finish        one-cycle pulse when byte + ack bit are complete
//   o_data_out      received byte, held until the next completed byte
//   i_sda_in        sampled SDA line
//   o_sda_oe        1 = pull SDA low, 0 = release
//   o_scl           SCL drive value
module i2c_master_read_byte
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_go,
    input  logic                  i_ack_en,
    output logic                  o_finish,
    output logic [DATA_WIDTH-1:0] o_data_out,
    input  logic                  i_sda_in,
    output logic                  o_sda_oe,
    output logic                  o_scl
);

    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_ack_en;
    logic                  r_bus_used;
    logic                  r_finish;
    logic                  r_sda_oe;

    logic w_accept;
    logic w_run;
    logic w_scl_idle;
    logic w_sda_oe_next;
    logic w_finish_next;
    logic w_sample;
    logic w_last;

    i2c_bit_timer u_bit_timer (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_run          (w_run),
        .i_scl_idle     (w_scl_idle),
        .o_scl          (o_scl),
        .o_sample_c     (w_sample),
        .o_last_phase_c (w_last)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_run         = 1'b0;
        w_scl_idle    = 1'b0;
        w_sda_oe_next = 1'b0;
        w_finish_next = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_go && !r_finish) begin
                    w_next_state = ST_READ;
                    w_accept     = 1'b1;
                end
            end
            ST_READ: begin
                w_run = i_go;
                if (!i_go) begin
                    w_next_state = ST_IDLE;
                end else if (w_last && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                w_run = i_go;
                if (!i_go) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_TAIL;
                end
            end
            ST_TAIL: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // SCL idles high only until this block has first taken the bus.
        w_scl_idle = (w_next_state == ST_IDLE) && !r_bus_used;

        // Ack level is held through TAIL so SDA is released only with SCL low.
        if ((w_next_state == ST_ACK) || (w_next_state == ST_TAIL)) begin
            w_sda_oe_next = r_ack_en ? SDA_OE_ACK : SDA_OE_NACK;
        end

        w_finish_next = (w_next_state == ST_TAIL);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: shift register, bit counter, captured byte and output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_ack_en   <= 1'b0;
            r_bus_used <= 1'b0;
            r_finish   <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_finish <= w_finish_next;
            r_sda_oe <= w_sda_oe_next;

            if (w_accept) begin
                r_ack_en   <= i_ack_en;
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_bus_used <= 1'b1;
            end

            if ((r_state == ST_READ) && w_sample) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], i_sda_in};
            end

            if ((r_state == ST_READ) && i_go && w_last && (r_bit_cnt != LAST_BIT)) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end

            if ((r_state == ST_READ) && (w_next_state == ST_ACK)) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign o_finish   = r_finish;
    assign o_data_out = r_data_out;
    assign o_sda_oe   = r_sda_oe;

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Testbench for i2c_master_read_byte: transfer-level reference model checked
// every cycle, directed bus scenarios with literal expectations, and a
// randomized free-running go/SDA phase.
module tb_i2c_master_read_byte;

    localparam int XFER_LEN = 73;  // cycles from first READ cycle through TAIL

    logic       clock = 1'b0;
    logic       reset_n;
    logic       go;
    logic       ack_en;
    logic       sda_in;
    logic       finish;
    logic [7:0] data_out;
    logic       sda_oe;
    logic       scl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fin = 0;

    i2c_master_read_byte #(.DATA_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_go       (go),
        .i_ack_en   (ack_en),
        .o_finish   (finish),
        .o_data_out (data_out),
        .i_sda_in   (sda_in),
        .o_sda_oe   (sda_oe),
        .o_scl      (scl)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a transfer is a linear timeline of 73 cycles indexed by
    // m_k (0..63 data bits, 64..71 ack slot, 72 finish cycle).
    bit         m_busy;
    bit         m_used;
    int         m_k;
    logic       m_ack;
    logic [7:0] m_byte;
    logic [7:0] m_data;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_used = 0; m_k = 0; m_ack = 0; m_byte = 0; m_data = 0;
        end else if (!m_busy) begin
            if (go) begin
                m_busy = 1; m_used = 1; m_k = 0; m_ack = ack_en; m_byte = 0;
            end
        end else if (m_k == XFER_LEN - 1 || !go) begin
            m_busy = 0;
        end else begin
            // Bit b of the transfer is sampled 5 clocks into its 8-clock slot.
            if (m_k < 64 && m_k % 8 == 5) m_byte[7 - m_k / 8] = sda_in;
            if (m_k == 63) m_data = m_byte;
            m_k++;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic       e_scl, e_oe, e_fin;
        logic [7:0] e_data;
        if (!reset_n) begin
            e_scl = 1; e_oe = 0; e_fin = 0; e_data = 0;
        end else if (!m_busy) begin
            e_scl = !m_used; e_oe = 0; e_fin = 0; e_data = m_data;
        end else begin
            e_scl  = (m_k < 72) && ((m_k % 8) >= 4);
            e_oe   = (m_k >= 64) ? m_ack : 1'b0;
            e_fin  = (m_k == 72);
            e_data = m_data;
        end
        check("scl", 32'(scl), 32'(e_scl));
        check("sda_oe", 32'(sda_oe), 32'(e_oe));
        check("finish", 32'(finish), 32'(e_fin));
        check("data_out", 32'(data_out), 32'(e_data));
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Drives one transfer acting as the slave: SDA changes at phase 0 of each
    // bit, optionally glitched at phase 6. Must start in an IDLE cycle.
    task automatic xfer(input logic [7:0] b, input logic ack, input bit glitch,
                        input bit keep_go, input int abort_k, input int reset_k,
                        input logic [7:0] held_data);
        int n;
        go = 1; ack_en = ack; n = cyc;
        step();
        for (int k = 0; k < XFER_LEN; k++) begin
            if (k < 64) sda_in = (glitch && k % 8 == 6) ? ~b[7 - k / 8] : b[7 - k / 8];
            else        sda_in = 1'($urandom);
            ack_en = 1'($urandom);
            if (k == abort_k) begin
                go = 0;
                step();
                check("abort_scl", 32'(scl), 32'(0));
                check("abort_oe", 32'(sda_oe), 32'(0));
                check("abort_fin", 32'(finish), 32'(0));
                check("abort_data", 32'(data_out), 32'(held_data));
                return;
            end
            if (k == reset_k) begin
                go = 0;
                reset_n = 0;
                #1;
                check("rst_scl", 32'(scl), 32'(1));
                check("rst_oe", 32'(sda_oe), 32'(0));
                check("rst_fin", 32'(finish), 32'(0));
                check("rst_data", 32'(data_out), 32'(0));
                step();
                step();
                reset_n = 1;
                step();
                return;
            end
            if (k >= 64) check("ack_oe", 32'(sda_oe), 32'(ack));
            if (k == XFER_LEN - 1) begin
                check("fin_pulse", 32'(finish), 32'(1));
                check("fin_data", 32'(data_out), 32'(b));
                check("fin_latency", 32'(cyc - n), 32'(XFER_LEN));
                last_fin = cyc;
                go = keep_go;
            end
            step();
        end
        check("fin_one_cycle", 32'(finish), 32'(0));
    endtask

    initial begin
        int f1;
        reset_n = 0; go = 0; ack_en = 0; sda_in = 1;
        repeat (3) @(posedge clock);
        #2;
        check("reset_scl", 32'(scl), 32'(1));
        check("reset_data", 32'(data_out), 32'(0));
        reset_n = 1;
        step(); step();
        check("idle_scl_fresh", 32'(scl), 32'(1));

        xfer(8'hA5, 1, 0, 0, -1, -1, 8'h00);
        check("idle_scl_after", 32'(scl), 32'(0));
        xfer(8'h3C, 0, 0, 0, -1, -1, 8'h00);
        xfer(8'h00, 1, 1, 0, -1, -1, 8'h00);

        xfer(8'hFF, 1, 0, 1, -1, -1, 8'h00);
        f1 = last_fin;
        xfer(8'h01, 0, 0, 0, -1, -1, 8'h00);
        check("b2b_spacing", 32'(last_fin - f1), 32'(XFER_LEN + 1));

        xfer(8'hA5, 1, 0, 0, -1, -1, 8'h00);
        xfer(8'h77, 1, 0, 0, 26, -1, 8'hA5);
        step();
        xfer(8'h5A, 1, 0, 0, -1, -1, 8'h00);

        xfer(8'hC3, 1, 0, 0, -1, 67, 8'h00);
        check("post_rst_scl", 32'(scl), 32'(1));
        xfer(8'h96, 0, 0, 0, -1, -1, 8'h00);

        repeat (4) xfer(8'($urandom), 1'($urandom), 0, 0, -1, -1, 8'h00);

        // Free-running phase: random go hold lengths give completions,
        // back-to-back bytes and aborts at arbitrary points; SDA random each cycle.
        for (int e = 0; e < 25; e++) begin
            int len;
            int gap;
            len = $urandom_range(20, 180);
            gap = $urandom_range(0, 4);
            go = 1;
            for (int c = 0; c < len; c++) begin
                sda_in = 1'($urandom);
                ack_en = 1'($urandom);
                step();
            end
            go = 0;
            for (int c = 0; c < gap; c++) begin
                sda_in = 1'($urandom);
                step();
            end
        end
        repeat (80) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
